// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-decode handshake and execute redirect bundle for instr_fetch_queue.
// master = fetch side, slave = decode/execute side.
interface instr_fetch_queue_if #(
  parameter int IW  = 32,
  parameter int PCW = 32
);
  logic           instr_valid;
  logic           instr_ready;
  logic [IW-1:0]  instr_out;
  logic [PCW-1:0] instr_pc;
  logic           redirect_valid;
  logic [PCW-1:0] redirect_pc;

  modport master (
    output instr_valid, instr_out, instr_pc,
    input  instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  instr_valid, instr_out, instr_pc,
    output instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: walks instruction_stream by byte PC into a prefetch FIFO
// drained by decode; execute redirects flush it. FETCH_PERF_CNT_EN adds push/flush counters.
module instr_fetch_queue #(
  parameter int IW         = 32,
  parameter int DEPTH      = 1024,
  parameter int PCW        = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IW*DEPTH-1:0] instruction_stream,
  instr_fetch_queue_if.master bus,
  output logic                halted,
  output logic                align_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]         fetched_cnt,
  output logic [31:0]         flushed_cnt
`endif
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int AW   = $clog2(DEPTH);
  localparam logic [PCW:0] PC_LIMIT = (PCW+1)'(4 * DEPTH);
  localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(FIFO_DEPTH);

  logic [PCW-1:0]  fetch_pc;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW:0]   count;
  logic [IW-1:0]   ins_mem [FIFO_DEPTH];
  logic [PCW-1:0]  pc_mem  [FIFO_DEPTH];
  logic [IW-1:0]   words   [DEPTH];

  logic [AW-1:0]   word_idx;
  logic            pc_in_range;
  logic            pop;
  logic            push;
  logic            redirect_misaligned;
  logic            redirect_in_range;

  for (genvar k = 0; k < DEPTH; k++) begin : g_words
    assign words[k] = instruction_stream[IW*k +: IW];
  end

  assign word_idx    = fetch_pc[AW+1:2];
  assign pc_in_range = {1'b0, fetch_pc} < PC_LIMIT;

  assign bus.instr_valid = (count != '0);
  assign bus.instr_out   = ins_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];

  assign pop  = bus.instr_valid & bus.instr_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push = !halted && pc_in_range && ((count != FULL_COUNT) || pop);

  assign redirect_misaligned = |bus.redirect_pc[1:0];
  assign redirect_in_range   = {1'b0, bus.redirect_pc} < PC_LIMIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halted    <= 1'b0;
      align_err <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        ins_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
`ifdef FETCH_PERF_CNT_EN
      fetched_cnt <= '0;
      flushed_cnt <= '0;
`endif
    end else if (bus.redirect_valid) begin
      // Redirect overrides the cycle's push and pop; queued entries are discarded.
      fetch_pc  <= bus.redirect_pc;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      align_err <= redirect_misaligned;
      halted    <= redirect_misaligned | !redirect_in_range;
`ifdef FETCH_PERF_CNT_EN
      flushed_cnt <= flushed_cnt + 32'(count);
`endif
    end else begin
      if (push) begin
        ins_mem[wr_ptr] <= words[word_idx];
        pc_mem[wr_ptr]  <= fetch_pc;
        wr_ptr          <= wr_ptr + PTRW'(1);
        fetch_pc        <= fetch_pc + PCW'(4);
`ifdef FETCH_PERF_CNT_EN
        fetched_cnt <= fetched_cnt + 32'd1;
`endif
      end
      if (!halted && !pc_in_range) begin
        halted <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTRW+1)'(1);
        2'b01:   count <= count - (PTRW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected {pc, instr} stream rebuilt on every
// reset/redirect, popped by an independent monitor on each accepted handshake.
module tb_instr_fetch_queue;
  localparam int IW    = 32;
  localparam int DEPTH = 16;
  localparam int PCW   = 32;
  localparam int FD    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic [IW*DEPTH-1:0] stream;
  logic                halted;
  logic                align_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]         fetched_cnt;
  logic [31:0]         flushed_cnt;
  logic [31:0]         flushed_base;
`endif

  instr_fetch_queue_if #(.IW(IW), .PCW(PCW)) bus ();

  instr_fetch_queue #(
    .IW(IW), .DEPTH(DEPTH), .PCW(PCW), .FIFO_DEPTH(FD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .instruction_stream (stream),
    .bus                (bus),
    .halted             (halted),
    .align_err          (align_err)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_cnt        (fetched_cnt),
    .flushed_cnt        (flushed_cnt)
`endif
  );

  typedef struct {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  instr;
  } item_t;

  item_t         exp_q[$];
  logic [IW-1:0] prog [DEPTH];
  int            vectors     = 0;
  int            miscompares = 0;

  // After reset or an aligned in-range redirect to t, decode must see t, t+4, ... to the end.
  function automatic void expect_from(input logic [PCW-1:0] target);
    exp_q.delete();
    if (target[1:0] == 2'b00 && target < 4*DEPTH) begin
      for (int unsigned a = target; a < 4*DEPTH; a += 4) begin
        exp_q.push_back('{pc: PCW'(a), instr: prog[a/4]});
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    item_t e;
    if (rst === 1'b0 && bus.redirect_valid === 1'b0 &&
        bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_delivery: got pc %0h, required no delivery", bus.instr_pc);
      end else begin
        e = exp_q.pop_front();
        if (bus.instr_pc !== e.pc || bus.instr_out !== e.instr) begin
          miscompares++;
          $display("FAIL delivery: got pc %0h instr %0h, required pc %0h instr %0h",
                   bus.instr_pc, bus.instr_out, e.pc, e.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_redirect(input logic [PCW-1:0] t);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = t;
    expect_from(t);
    step();
    bus.redirect_valid = 1'b0;
    check("redirect_align_err", 64'(align_err), 64'(|t[1:0]));
    check("redirect_halted", 64'(halted), 64'(|t[1:0]));
  endtask

  task automatic drain();
    int i;
    bus.instr_ready = 1'b1;
    i = 0;
    while (i < 200 && !(halted && !bus.instr_valid)) begin
      step();
      i++;
    end
    check("drain_done", 64'(halted && !bus.instr_valid), 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int r;
    for (int k = 0; k < DEPTH; k++) prog[k] = $urandom;
    prog[0]  = 32'h2001_0005;  // addi $1,$0,5
    prog[1]  = 32'h2002_0002;  // addi $2,$0,2
    prog[2]  = 32'h2003_0007;  // addi $3,$0,7
    prog[3]  = 32'h1022_0003;  // beq
    prog[4]  = 32'h2004_0001;
    prog[5]  = 32'h2005_0003;
    prog[6]  = 32'h1423_0005;  // bne
    prog[12] = 32'h0800_000D;  // j 52
    prog[13] = 32'h2007_000D;  // addi $7,$0,13
    for (int k = 0; k < DEPTH; k++) stream[IW*k +: IW] = prog[k];

    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    expect_from('0);

    // Reset values and first-word latency, with decode stalled.
    step();
    step();
    settle();
    check("rst_valid", 64'(bus.instr_valid), 64'd0);
    check("rst_instr_out", 64'(bus.instr_out), 64'd0);
    check("rst_instr_pc", 64'(bus.instr_pc), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_align_err", 64'(align_err), 64'd0);
    step();
    rst = 1'b0;
    step();
    settle();
    check("first_valid", 64'(bus.instr_valid), 64'd1);
    check("first_pc", 64'(bus.instr_pc), 64'd0);
    check("first_instr", 64'(bus.instr_out), 64'(prog[0]));

    repeat (9) step();
    settle();
    check("stall_valid", 64'(bus.instr_valid), 64'd1);
    check("stall_head_pc", 64'(bus.instr_pc), 64'd0);
    check("stall_head_instr", 64'(bus.instr_out), 64'(prog[0]));

    step();
    bus.instr_ready = 1'b1;
    repeat (3) step();
    bus.instr_ready = 1'b0;
    repeat (6) step();

    // Redirect to 24 with the FIFO full.
`ifdef FETCH_PERF_CNT_EN
    flushed_base = flushed_cnt;
`endif
    do_redirect(32'd24);
    settle();
    check("redirect_bubble", 64'(bus.instr_valid), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    check("flushed_delta", 64'(flushed_cnt - flushed_base), 64'd4);
`endif
    step();
    bus.instr_ready = 1'b1;
    repeat (4) step();

    // Misaligned target halts; an aligned one recovers.
    do_redirect(32'd26);
    repeat (3) step();
    settle();
    check("misaligned_no_valid", 64'(bus.instr_valid), 64'd0);
    step();
    do_redirect(32'd52);
    drain();

    // Randomized traffic.
    repeat (3000) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 199));
      if (r < 8) begin
        do_redirect(PCW'(4 * $urandom_range(0, DEPTH-1)));
      end else if (r < 10) begin
        do_redirect(PCW'(4 * $urandom_range(0, DEPTH-1) + $urandom_range(1, 3)));
      end else if (r == 10) begin
        rst = 1'b1;
        expect_from('0);
        step();
        rst = 1'b0;
      end else begin
        step();
      end
    end
    do_redirect(PCW'(4 * $urandom_range(0, DEPTH-1)));
    drain();

    // Reset while full: queue discarded, restart from PC 0.
    do_redirect('0);
    bus.instr_ready = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    expect_from('0);
    step();
    rst = 1'b0;
    settle();
    check("midrst_valid", 64'(bus.instr_valid), 64'd0);
    check("midrst_halted", 64'(halted), 64'd0);
    step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
